// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered load; SEG7_HEX_EN adds A..F glyphs.
// All outputs registered (one cycle after lt_n/bi_n/rbi_n change); no backpressure, load is always accepted.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lt_n,
  input  logic                    bi_n,
  input  logic                    rbi_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] act, act_nxt, pend;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt, pend_dp;
  logic                    pend_vld;
  logic                    slot_end, wrap;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    run_zero;
  logic [3:0]              code;
  logic                    dp_sel, sup;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
`ifdef SEG7_HEX_EN
      4'd10: s = 7'h77;
      4'd11: s = 7'h7C;
      4'd12: s = 7'h39;
      4'd13: s = 7'h5E;
      4'd14: s = 7'h79;
      4'd15: s = 7'h71;
`endif
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end   = (cnt == CW'(PRESCALE - 1));
    wrap       = slot_end && (idx == IW'(NUM_DIGITS - 1));
    cnt_nxt    = slot_end ? '0 : cnt + CW'(1);
    idx_nxt    = idx;
    if (slot_end) idx_nxt = wrap ? '0 : idx + IW'(1);
    act_nxt    = act;
    act_dp_nxt = act_dp;
    if (wrap) begin
      if (load) begin
        act_nxt    = bcd_in;
        act_dp_nxt = dp_in;
      end else if (pend_vld) begin
        act_nxt    = pend;
        act_dp_nxt = pend_dp;
      end
    end
  end

  // Outputs are computed from next-state values so the registered an_n lines up with the count it reflects.
  always_comb begin
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero && (act_nxt[4*k +: 4] == 4'd0);
      lead_zero[k] = run_zero;
    end
    code   = '0;
    dp_sel = 1'b0;
    sup    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        code   = act_nxt[4*k +: 4];
        dp_sel = act_dp_nxt[k];
        sup    = (k != 0) && lead_zero[k] && !rbi_n;
      end
    end
  end

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (bi_n) begin
      if (cnt_nxt != '0) an_d = ~(NUM_DIGITS'(1) << idx_nxt);
      if (!lt_n) begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
      end else begin
        dp_d = ~dp_sel;
        if (!sup) seg_d = ~decode(code);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      act        <= '0;
      act_dp     <= '0;
      pend       <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      act    <= act_nxt;
      act_dp <= act_dp_nxt;
      if (load && !wrap) begin
        pend     <= bcd_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_tick <= wrap;
    end
  end

endmodule
